// File: rtl/irq_pkg.sv
// Shared register map, FSM states and priority helper for the interrupt controller.
package irq_pkg;

   localparam int MAX_SRC = 16;

   localparam logic [4:0] OFF_PENDING = 5'h00;
   localparam logic [4:0] OFF_ENABLE  = 5'h04;
   localparam logic [4:0] OFF_EDGE    = 5'h08;
   localparam logic [4:0] OFF_CAUSE   = 5'h0C;
   localparam logic [4:0] OFF_EOI     = 5'h10;
   localparam logic [4:0] OFF_ICOUNT  = 5'h14;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      SERVICE
   } irq_state_t;

   // Lowest set index wins.
   function automatic logic [3:0] lowest_id(input logic [MAX_SRC-1:0] v);
      logic [3:0] id;
      id = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--)
         if (v[i]) id = 4'(i);
      return id;
   endfunction

endpackage

// File: rtl/irq_controller_sync.sv
// Per-source synchronizer chain with a rising-edge detector on the synced level.
module irq_src_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic src,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: I_Req/IACK handshake, EOI hold-off, memory-mapped regs.
// Define IRQ_COUNT_EN to add the ICOUNT acknowledge counter at offset 0x14.
module irq_controller
   import irq_pkg::*;
#(
   parameter int          NUM_SRC     = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_F000,
   parameter int          SYNC_STAGES = 2,
   parameter int          ACK_TIMEOUT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               I_Req,
   input  logic               IACK,
   input  logic [31:0]        bus_addr,
   input  logic [31:0]        bus_wdata,
   input  logic [3:0]         bus_we,
   output logic               bus_sel,
   output logic [31:0]        bus_rdata
);

   localparam int CW = $clog2(ACK_TIMEOUT);

   logic [NUM_SRC-1:0] level;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] pend_d;
   logic [NUM_SRC-1:0] en_q;
   logic [NUM_SRC-1:0] edge_q;
   logic [NUM_SRC-1:0] cand;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] ack_clr;
   logic [MAX_SRC-1:0] cand_ext;
   logic [3:0]         win;
   logic [3:0]         sel_id_q;
   logic [CW-1:0]      cnt_q;
   logic               cause_v_q;
   logic [3:0]         cause_id_q;
   logic [4:0]         off;
   logic               wr;
   logic               ack;
   logic               eoi;
   logic               timeout;
   logic [31:0]        rd;
   logic               unused_wdata;
   irq_state_t         state_q;
   irq_state_t         state_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      irq_src_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk  (clk),
         .reset(reset),
         .src  (irq_src[i]),
         .level(level[i]),
         .rise (rise[i])
      );
   end

   assign bus_sel = (bus_addr[31:5] == BASE_ADDR[31:5]);
   assign off     = bus_addr[4:0];
   assign wr      = bus_sel & (bus_we == 4'b1111);
   assign ack     = (state_q == WAIT_ACK) & IACK;
   assign eoi     = wr & (off == OFF_EOI) & (state_q == SERVICE);
   assign timeout = (cnt_q == CW'(ACK_TIMEOUT - 1));
   assign cand    = pend_q & en_q;

   always_comb begin
      cand_ext = '0;
      cand_ext[NUM_SRC-1:0] = cand;
   end

   assign win = lowest_id(cand_ext);

   assign w1c = (wr && off == OFF_PENDING) ?
                bus_wdata[NUM_SRC-1:0] : '0;
   assign ack_clr = ack ?
                    (edge_q & (NUM_SRC'(1) << sel_id_q)) : '0;

   // A fresh edge beats any clear landing in the same cycle.
   assign pend_d = (edge_q & (rise | (pend_q & ~w1c & ~ack_clr)))
                 | (~edge_q & level);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         en_q   <= '0;
         edge_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (wr && off == OFF_ENABLE)
            en_q <= bus_wdata[NUM_SRC-1:0];
         if (wr && off == OFF_EDGE)
            edge_q <= bus_wdata[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (cand != '0) state_d = REQ;
         REQ:      state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (IACK)
               state_d = SERVICE;
            else if (timeout)
               state_d = REQ;
         end
         SERVICE:  if (eoi) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      I_Req = (state_q == REQ);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_id_q   <= '0;
         cnt_q      <= '0;
         cause_v_q  <= 1'b0;
         cause_id_q <= '0;
      end else begin
         if (state_q == IDLE && cand != '0)
            sel_id_q <= win;
         if (state_q == REQ)
            cnt_q <= '0;
         else if (state_q == WAIT_ACK)
            cnt_q <= cnt_q + CW'(1);
         if (ack) begin
            cause_v_q  <= 1'b1;
            cause_id_q <= sel_id_q;
         end else if (eoi) begin
            cause_v_q <= 1'b0;
         end
      end
   end

`ifdef IRQ_COUNT_EN
   logic [31:0] icount_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         icount_q <= '0;
      else if (wr && off == OFF_ICOUNT)
         icount_q <= '0;
      else if (ack)
         icount_q <= icount_q + 32'd1;
   end
`endif

   always_comb begin
      rd = '0;
      if (bus_sel) begin
         case (off)
            OFF_PENDING: rd[NUM_SRC-1:0] = pend_q;
            OFF_ENABLE:  rd[NUM_SRC-1:0] = en_q;
            OFF_EDGE:    rd[NUM_SRC-1:0] = edge_q;
            OFF_CAUSE:   rd = {cause_v_q, 27'b0, cause_id_q};
`ifdef IRQ_COUNT_EN
            OFF_ICOUNT:  rd = icount_q;
`endif
            default:     rd = '0;
         endcase
      end
   end

   assign bus_rdata = rd;

   assign unused_wdata = ^bus_wdata[31:NUM_SRC];

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a cycle-level reference model.
module tb_irq_controller;

   localparam int          N    = 8;
   localparam int          SYNC = 2;
   localparam int          AT   = 4;
   localparam logic [31:0] BASE = 32'h0000_F000;

   localparam logic [31:0] A_PEND  = BASE;
   localparam logic [31:0] A_EN    = BASE + 32'h04;
   localparam logic [31:0] A_EDGE  = BASE + 32'h08;
   localparam logic [31:0] A_CAUSE = BASE + 32'h0C;
   localparam logic [31:0] A_EOI   = BASE + 32'h10;
   localparam logic [31:0] A_ICNT  = BASE + 32'h14;

   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_WAIT = 2;
   localparam int P_SVC  = 3;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic [N-1:0] irq_src   = '0;
   logic         I_Req;
   logic         IACK      = 1'b0;
   logic [31:0]  bus_addr  = BASE;
   logic [31:0]  bus_wdata = '0;
   logic [3:0]   bus_we    = '0;
   logic         bus_sel;
   logic [31:0]  bus_rdata;

   int passed = 0;
   int total  = 0;
   int npulse = 0;

   irq_controller #(
      .NUM_SRC    (N),
      .BASE_ADDR  (BASE),
      .SYNC_STAGES(SYNC),
      .ACK_TIMEOUT(AT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .irq_src  (irq_src),
      .I_Req    (I_Req),
      .IACK     (IACK),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_we   (bus_we),
      .bus_sel  (bus_sel),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: raw-sample history, register image, handshake phase.
   logic [N-1:0] hist [0:SYNC];
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] m_en   = '0;
   logic [N-1:0] m_edge = '0;
   int           m_phase = P_IDLE;
   int           m_sel   = 0;
   int           m_tmr   = 0;
   bit           m_cv    = 1'b0;
   logic [3:0]   m_cid   = '0;
   logic [31:0]  m_icnt  = '0;

   initial foreach (hist[i]) hist[i] = '0;

   function automatic bit in_win(input logic [31:0] a);
      return (a >= BASE) && (a <= BASE + 32'h1F);
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      if (in_win(a)) begin
         case (a - BASE)
            32'h00: r = 32'(m_pend);
            32'h04: r = 32'(m_en);
            32'h08: r = 32'(m_edge);
            32'h0C: r = {m_cv, 27'b0, m_cid};
`ifdef IRQ_COUNT_EN
            32'h14: r = m_icnt;
`endif
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      logic [N-1:0] lvl;
      logic [N-1:0] rs;
      logic [N-1:0] w1c;
      logic [N-1:0] akm;
      logic [N-1:0] np;
      bit           wr;
      logic [31:0]  off;
      if (reset) begin
         foreach (hist[i]) hist[i] = '0;
         m_pend  = '0;
         m_en    = '0;
         m_edge  = '0;
         m_phase = P_IDLE;
         m_sel   = 0;
         m_tmr   = 0;
         m_cv    = 1'b0;
         m_cid   = '0;
         m_icnt  = '0;
      end else begin
         lvl = hist[SYNC-1];
         rs  = lvl & ~hist[SYNC];
         wr  = in_win(bus_addr) && (bus_we == 4'hF);
         off = bus_addr - BASE;
         w1c = (wr && off == 0) ? bus_wdata[N-1:0] : '0;
         akm = '0;
         case (m_phase)
            P_IDLE: begin
               if ((m_pend & m_en) != '0) begin
                  for (int i = N - 1; i >= 0; i--)
                     if (m_pend[i] && m_en[i]) m_sel = i;
                  m_phase = P_REQ;
               end
            end
            P_REQ: begin
               m_tmr   = 0;
               m_phase = P_WAIT;
            end
            P_WAIT: begin
               if (IACK) begin
                  m_cv  = 1'b1;
                  m_cid = 4'(m_sel);
                  if (m_edge[m_sel]) akm[m_sel] = 1'b1;
                  m_icnt  = m_icnt + 1;
                  m_phase = P_SVC;
               end else if (m_tmr == AT - 1) begin
                  m_phase = P_REQ;
               end else begin
                  m_tmr++;
               end
            end
            default: begin
               if (wr && off == 32'h10) begin
                  m_cv    = 1'b0;
                  m_phase = P_IDLE;
               end
            end
         endcase
         for (int i = 0; i < N; i++)
            np[i] = m_edge[i] ? (rs[i] | (m_pend[i] & ~w1c[i] & ~akm[i]))
                              : lvl[i];
         m_pend = np;
         if (wr && off == 32'h04) m_en   = bus_wdata[N-1:0];
         if (wr && off == 32'h08) m_edge = bus_wdata[N-1:0];
         if (wr && off == 32'h14) m_icnt = '0;
         for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = irq_src;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("irq_req", 32'(I_Req), 32'(m_phase == P_REQ));
         check("bus_sel", 32'(bus_sel), 32'(in_win(bus_addr)));
         check("rdata", bus_rdata, mread(bus_addr));
         if (I_Req) npulse++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] we);
      bus_addr  = a;
      bus_wdata = d;
      bus_we    = we;
      cyc();
      bus_we    = '0;
      bus_wdata = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus_addr = a;
      bus_we   = '0;
      @(negedge clk);
      #1;
      d = bus_rdata;
      cyc();
   endtask

   // Cycles from now until I_Req is seen (0 if never); ends one cycle later.
   task automatic gap(output int n);
      n = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         #1;
         if (I_Req) begin
            n = k;
            break;
         end
      end
      cyc();
   endtask

   task automatic ack();
      IACK = 1'b1;
      cyc();
      IACK = 1'b0;
   endtask

   initial begin
      int          n;
      int          p0;
      logic [31:0] d;

      idle(3);
      reset = 1'b0;
      check("rst_ireq", 32'(I_Req), 32'h0);
      rd(A_PEND, d);  check("rst_pend", d, 32'h0);
      rd(A_EN, d);    check("rst_en", d, 32'h0);
      rd(A_CAUSE, d); check("rst_cause", d, 32'h0);

      // Two simultaneous edges: src0 first, src2 after EOI.
      wr(A_EN, 32'h05, 4'hF);
      wr(A_EDGE, 32'h05, 4'hF);
      p0 = npulse;
      irq_src = 8'h05;
      gap(n); check("t1_req0", 32'(n != 0), 32'h1);
      ack();
      rd(A_CAUSE, d); check("t1_cause0", d, 32'h8000_0000);
      rd(A_PEND, d);  check("t1_pend", d, 32'h0000_0004);
      idle(4);
      check("t1_one_pulse", 32'(npulse - p0), 32'd1);
      wr(A_EOI, 32'h0, 4'hF);
      gap(n); check("t1_req2", 32'(n != 0), 32'h1);
      ack();
      rd(A_CAUSE, d); check("t1_cause2", d, 32'h8000_0002);
      check("t1_two_pulses", 32'(npulse - p0), 32'd2);
      wr(A_EOI, 32'h0, 4'hF);
      irq_src = '0;
      idle(4);

      // Unacknowledged request re-issues every ACK_TIMEOUT+1 cycles.
      wr(A_EN, 32'h08, 4'hF);
      wr(A_EDGE, 32'h08, 4'hF);
      irq_src = 8'h08;
      gap(n); check("t2_req", 32'(n != 0), 32'h1);
      gap(n); check("t2_gap1", 32'(n), 32'd5);
      gap(n); check("t2_gap2", 32'(n), 32'd5);
      ack();
      rd(A_CAUSE, d); check("t2_cause", d, 32'h8000_0003);
      p0 = npulse;
      idle(12);
      check("t2_no_more", 32'(npulse - p0), 32'd0);
      wr(A_EOI, 32'h0, 4'hF);
      irq_src = '0;
      idle(4);

      // Level source held through EOI, then dropped before EOI.
      wr(A_EN, 32'h02, 4'hF);
      wr(A_EDGE, 32'h00, 4'hF);
      irq_src = 8'h02;
      gap(n); check("t3_req", 32'(n != 0), 32'h1);
      ack();
      rd(A_CAUSE, d); check("t3_cause", d, 32'h8000_0001);
      rd(A_PEND, d);  check("t3_pend_hi", d, 32'h0000_0002);
      wr(A_EOI, 32'h0, 4'hF);
      gap(n); check("t3_reissue", 32'(n), 32'd2);
      ack();
      irq_src = '0;
      idle(4);
      rd(A_PEND, d);  check("t3_pend_lo", d, 32'h0);
      p0 = npulse;
      wr(A_EOI, 32'h0, 4'hF);
      idle(8);
      check("t3_no_req", 32'(npulse - p0), 32'd0);

      // W1C colliding with a new edge: the edge must win.
      wr(A_EN, 32'h00, 4'hF);
      wr(A_EDGE, 32'h10, 4'hF);
      irq_src = 8'h10;
      idle(4);
      irq_src = '0;
      idle(3);
      rd(A_PEND, d);  check("t4_set", d, 32'h0000_0010);
      wr(A_PEND, 32'h10, 4'hF);
      rd(A_PEND, d);  check("t4_w1c", d, 32'h0);
      irq_src = 8'h10;
      idle(2);
      wr(A_PEND, 32'h10, 4'hF);
      rd(A_PEND, d);  check("t4_set_wins", d, 32'h0000_0010);
      irq_src = '0;
      wr(A_PEND, 32'h10, 4'hF);
      idle(2);

      // Reset in the middle of a handshake.
      wr(A_EN, 32'h01, 4'hF);
      wr(A_EDGE, 32'h01, 4'hF);
      irq_src = 8'h01;
      gap(n); check("t5_req", 32'(n != 0), 32'h1);
      reset    = 1'b1;
      bus_addr = A_EN;
      #1;
      check("t5_ireq", 32'(I_Req), 32'h0);
      check("t5_en", bus_rdata, 32'h0);
      bus_addr = A_CAUSE;
      #1;
      check("t5_cause", bus_rdata, 32'h0);
      irq_src = '0;
      cyc();
      reset = 1'b0;
      p0 = npulse;
      ack();
      idle(8);
      check("t5_no_req", 32'(npulse - p0), 32'd0);
      rd(A_CAUSE, d); check("t5_cause_after", d, 32'h0);

      // Three acknowledged interrupts, counter clear, partial write.
      wr(A_EN, 32'h01, 4'hF);
      wr(A_EDGE, 32'h01, 4'hF);
      for (int k = 0; k < 3; k++) begin
         irq_src = 8'h01;
         gap(n); check("t6_req", 32'(n != 0), 32'h1);
         ack();
         wr(A_EOI, 32'h0, 4'hF);
         irq_src = '0;
         idle(3);
      end
      rd(A_ICNT, d);
`ifdef IRQ_COUNT_EN
      check("t6_icount", d, 32'd3);
`else
      check("t6_icount", d, 32'd0);
`endif
      wr(A_ICNT, 32'h1234, 4'hF);
      rd(A_ICNT, d);  check("t6_icount_clr", d, 32'd0);
      wr(A_EN, 32'hFF, 4'b0001);
      rd(A_EN, d);    check("t6_partial", d, 32'h0000_0001);

      // IACK while idle, unmapped offset, outside the window.
      IACK = 1'b1;
      idle(2);
      IACK = 1'b0;
      rd(A_CAUSE, d); check("t7_iack_idle", d, 32'h0);
      rd(BASE + 32'h18, d); check("t7_unmapped", d, 32'h0);
      bus_addr = BASE + 32'h20;
      @(negedge clk);
      #1;
      check("t7_sel_out", 32'(bus_sel), 32'h0);
      check("t7_rd_out", bus_rdata, 32'h0);
      cyc();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
